// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed common-anode seven-segment driver with a frame-coherent digit snapshot.
// Optional leading-zero suppression is built when the macro SEG_SCAN_LZS_EN is defined.
module seg_scan_display #(
    parameter int DIGITS   = 4,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int DIV_BITS = 18
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic [SEL_W-1:0]            sel,
    input  logic [NUM_SRC*DIGITS*4-1:0] src_data,
    input  logic                        hold,
    input  logic [DIGITS-1:0]           blank_mask,
    input  logic [DIGITS-1:0]           dp_mask,
    output logic [6:0]                  dispcode,
    output logic                        dp,
    output logic [DIGITS-1:0]           an,
    output logic                        frame_tick
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int               SNAP_W   = DIGITS * 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_encode = 7'b0000001;
            4'h1:    seg_encode = 7'b1001111;
            4'h2:    seg_encode = 7'b0010010;
            4'h3:    seg_encode = 7'b0000110;
            4'h4:    seg_encode = 7'b1001100;
            4'h5:    seg_encode = 7'b0100100;
            4'h6:    seg_encode = 7'b0100000;
            4'h7:    seg_encode = 7'b0001111;
            4'h8:    seg_encode = 7'b0000000;
            4'h9:    seg_encode = 7'b0000100;
            4'hA:    seg_encode = 7'b0001000;
            4'hB:    seg_encode = 7'b1100000;
            4'hC:    seg_encode = 7'b0110001;
            4'hD:    seg_encode = 7'b1000010;
            4'hE:    seg_encode = 7'b0110000;
            4'hF:    seg_encode = 7'b0111000;
            default: seg_encode = 7'b1111110;
        endcase
    endfunction

    logic [DIV_BITS-1:0] presc_r;
    logic [IDX_W-1:0]    idx_r;
    logic [SNAP_W-1:0]   snap_r;
    logic                load_pending_r;
    logic                frame_tick_r;
    logic [DIGITS-1:0]   an_r;
    logic [6:0]          dispcode_r;
    logic                dp_r;

    logic                scan_tick_s;
    logic                wrap_s;
    logic                load_s;
    logic [SNAP_W-1:0]   chan_s;
    logic [DIGITS-1:0]   lz_sup_s;
    logic [DIGITS-1:0]   an_next_s;
    logic [3:0]          cur_nib_s;
    logic                cur_blank_s;
    logic                cur_dp_s;
    logic                cur_sup_s;
    logic [6:0]          seg_next_s;
    logic                dp_next_s;

    assign scan_tick_s = &presc_r;
    assign wrap_s      = scan_tick_s & (idx_r == LAST_IDX);
    assign load_s      = load_pending_r | (wrap_s & ~hold);

    // Source channel mux; any out-of-range select falls back to channel 0.
    always_comb begin
        chan_s = src_data[SNAP_W-1:0];
        for (int c = 1; c < NUM_SRC; c++) begin
            chan_s = (32'(sel) == 32'(c)) ? src_data[c*SNAP_W +: SNAP_W] : chan_s;
        end
    end

`ifdef SEG_SCAN_LZS_EN
    logic zeros_above_s;

    // A digit is suppressed when it and every higher snapshot digit are zero; digit 0 always shows.
    always_comb begin
        zeros_above_s = 1'b1;
        lz_sup_s      = {DIGITS{1'b0}};
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zeros_above_s = zeros_above_s & (snap_r[d*4 +: 4] == 4'h0);
            lz_sup_s[d]   = zeros_above_s;
        end
    end
`else
    assign lz_sup_s = {DIGITS{1'b0}};
`endif

    // Pick the active digit's nibble, masks and anode pattern from the current scan index.
    always_comb begin
        an_next_s   = {DIGITS{1'b1}};
        cur_nib_s   = snap_r[3:0];
        cur_blank_s = blank_mask[0];
        cur_dp_s    = dp_mask[0];
        cur_sup_s   = lz_sup_s[0];
        for (int d = 0; d < DIGITS; d++) begin
            an_next_s[d] = (idx_r != IDX_W'(d));
            cur_nib_s    = (idx_r == IDX_W'(d)) ? snap_r[d*4 +: 4] : cur_nib_s;
            cur_blank_s  = (idx_r == IDX_W'(d)) ? blank_mask[d]    : cur_blank_s;
            cur_dp_s     = (idx_r == IDX_W'(d)) ? dp_mask[d]       : cur_dp_s;
            cur_sup_s    = (idx_r == IDX_W'(d)) ? lz_sup_s[d]      : cur_sup_s;
        end
    end

    // Blanking darkens the decimal point too; suppression only darkens the segments.
    always_comb begin
        if (cur_blank_s) begin
            seg_next_s = SEG_OFF;
            dp_next_s  = 1'b1;
        end else if (cur_sup_s) begin
            seg_next_s = SEG_OFF;
            dp_next_s  = ~cur_dp_s;
        end else begin
            seg_next_s = seg_encode(cur_nib_s);
            dp_next_s  = ~cur_dp_s;
        end
    end

    // Free-running prescaler and scan index.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            presc_r <= {DIV_BITS{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            presc_r <= presc_r + DIV_BITS'(1'b1);
            if (scan_tick_s) begin
                idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
            end
        end
    end

    // Snapshot capture: once after reset regardless of hold, then at each frame boundary unless held.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            snap_r         <= {SNAP_W{1'b0}};
            load_pending_r <= 1'b1;
            frame_tick_r   <= 1'b0;
        end else begin
            load_pending_r <= 1'b0;
            frame_tick_r   <= load_s;
            if (load_s) begin
                snap_r <= chan_s;
            end
        end
    end

    // Anode, segments and decimal point share one register stage so they always change together.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            an_r       <= {DIGITS{1'b1}};
            dispcode_r <= SEG_OFF;
            dp_r       <= 1'b1;
        end else begin
            an_r       <= an_next_s;
            dispcode_r <= seg_next_s;
            dp_r       <= dp_next_s;
        end
    end

    assign an         = an_r;
    assign dispcode   = dispcode_r;
    assign dp         = dp_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: cycle-level reference model plus directed checks.
// Leading-zero expectations follow the SEG_SCAN_LZS_EN macro.
module tb_seg_scan_display;

    localparam int DIGITS    = 4;
    localparam int NUM_SRC   = 3;
    localparam int SEL_W     = 2;
    localparam int DIV_BITS  = 2;
    localparam int PER_DIGIT = 1 << DIV_BITS;
    localparam int FRAME     = PER_DIGIT * DIGITS;
`ifdef SEG_SCAN_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic                        CLK = 1'b0;
    logic                        Reset;
    logic [SEL_W-1:0]            sel;
    logic [NUM_SRC*DIGITS*4-1:0] src_data;
    logic                        hold;
    logic [DIGITS-1:0]           blank_mask;
    logic [DIGITS-1:0]           dp_mask;
    logic [6:0]                  dispcode;
    logic                        dp;
    logic [DIGITS-1:0]           an;
    logic                        frame_tick;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: clocks since reset release and the snapshot being displayed.
    int                  j;
    logic [DIGITS*4-1:0] m_snap;
    logic [DIGITS-1:0]   exp_an;
    logic [6:0]          exp_seg;
    logic                exp_dp;
    logic                exp_ft;

    logic [6:0] seg_tab [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg_scan_display #(
        .DIGITS(DIGITS), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DIV_BITS(DIV_BITS)
    ) dut (
        .CLK(CLK), .Reset(Reset), .sel(sel), .src_data(src_data), .hold(hold),
        .blank_mask(blank_mask), .dp_mask(dp_mask), .dispcode(dispcode), .dp(dp),
        .an(an), .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock; the digit shown after clock j is the one scanned during clock j-1.
    task automatic tick();
        int idx;
        int ch;
        @(posedge CLK);
        j++;
        idx = ((j - 1) / PER_DIGIT) % DIGITS;
        exp_an = '1;
        exp_an[idx] = 1'b0;
        if (blank_mask[idx]) begin
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
        end else begin
            exp_dp = ~dp_mask[idx];
            if (LZS && idx > 0 && (m_snap >> (4 * idx)) == '0) exp_seg = 7'b1111111;
            else exp_seg = seg_tab[m_snap[4*idx +: 4]];
        end
        exp_ft = (j == 1) || ((j % FRAME) == 0 && !hold);
        if (exp_ft) begin
            ch = (int'(sel) < NUM_SRC) ? int'(sel) : 0;
            m_snap = src_data[ch*DIGITS*4 +: DIGITS*4];
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 1'b0; sel = '0; hold = 1'b0; blank_mask = '0; dp_mask = '0;
        src_data = 48'({$urandom, $urandom});
        src_data[15:0] = 16'h12AF;
        repeat (3) @(negedge CLK);
        tests_run++;
        if ({an, dispcode, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got an=%b seg=%b dp=%b ft=%b, want 1111 1111111 1 0", an, dispcode, dp, frame_tick);
        end
        Reset = 1'b1;
        j = 0;
        m_snap = '0;
    endtask

    task automatic test_basic_scan();
        logic [10:0] want;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            tests_run++;
            if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                tests_failed++;
                $display("FAIL basic_model j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
            want = '0;
            case (j)
                3:  want = {4'b1110, 7'b0111000};
                7:  want = {4'b1101, 7'b0001000};
                11: want = {4'b1011, 7'b0010010};
                15: want = {4'b0111, 7'b1001111};
                default: want = '0;
            endcase
            if (want != '0) begin
                tests_run++;
                if ({an, dispcode} !== want) begin
                    tests_failed++;
                    $display("FAIL basic_digit j=%0d: got an=%b seg=%b, want %b", j, an, dispcode, want);
                end
            end
        end
    endtask

    task automatic test_sel_switch();
        int ft_at = -1;
        for (int k = 0; k < FRAME && ((j / PER_DIGIT) % DIGITS) != 1; k++) tick();
        src_data[2*16 +: 16] = 16'h3456;
        sel = 2'd2;
        for (int k = 0; k < 2 * FRAME && ft_at < 0; k++) begin
            tick();
            tests_run++;
            if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                tests_failed++;
                $display("FAIL sel_model j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
            if (frame_tick === 1'b1) ft_at = j;
        end
        tests_run++;
        if (ft_at < 0) begin
            tests_failed++;
            $display("FAIL sel_frame_tick: got no pulse, want one within %0d cycles", 2 * FRAME);
        end else begin
            tick();
            if ({an, dispcode} !== {4'b1110, 7'b0100000}) begin
                tests_failed++;
                $display("FAIL sel_first_digit: got an=%b seg=%b, want 1110 0100000", an, dispcode);
            end
        end
    endtask

    task automatic test_hold();
        int ft_count = 0;
        sel = 2'd0;
        hold = 1'b1;
        src_data[15:0] = 16'h789C;
        src_data[47:32] = 16'($urandom);
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            tests_run++;
            if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                tests_failed++;
                $display("FAIL hold_model j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
            if (frame_tick === 1'b1) ft_count++;
        end
        tests_run++;
        if (ft_count != 0) begin
            tests_failed++;
            $display("FAIL hold_frozen: got %0d frame_tick pulses, want 0", ft_count);
        end
        hold = 1'b0;
        ft_count = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            tests_run++;
            if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                tests_failed++;
                $display("FAIL release_model j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
            if (frame_tick === 1'b1) ft_count++;
        end
        tests_run++;
        if (ft_count != 1) begin
            tests_failed++;
            $display("FAIL hold_release: got %0d frame_tick pulses, want 1", ft_count);
        end
    endtask

    task automatic test_masks();
        blank_mask = 4'b0100;
        dp_mask    = 4'b0001;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            tests_run++;
            if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                tests_failed++;
                $display("FAIL mask_model j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
            if (an === 4'b1011) begin
                tests_run++;
                if ({dispcode, dp} !== {7'b1111111, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL mask_blank: got seg=%b dp=%b, want 1111111 1", dispcode, dp);
                end
            end
            if (an === 4'b1110) begin
                tests_run++;
                if (dp !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL mask_dp: got dp=%b, want 0", dp);
                end
            end
        end
        blank_mask = '0;
        dp_mask    = '0;
    endtask

    task automatic test_lzs();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        logic [6:0]  want;
        for (int v = 0; v < 2; v++) begin
            src_data[15:0] = vals[v];
            for (int k = 0; k < 2 * FRAME; k++) begin
                tick();
                tests_run++;
                if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                    tests_failed++;
                    $display("FAIL lzs_model j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
                end
`ifdef SEG_SCAN_LZS_EN
                if (k >= FRAME) begin
                    if (an === 4'b1110) want = 7'b0000001;
                    else if (an === 4'b1101 && v == 0) want = 7'b0100100;
                    else want = 7'b1111111;
                    tests_run++;
                    if (dispcode !== want) begin
                        tests_failed++;
                        $display("FAIL lzs_digit val=%h an=%b: got seg=%b, want %b", vals[v], an, dispcode, want);
                    end
                end
`endif
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) src_data = 48'({$urandom, $urandom});
            if ($urandom_range(0, 5) == 0) sel = SEL_W'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            blank_mask = 4'($urandom) & 4'($urandom);
            dp_mask    = 4'($urandom);
            tick();
            tests_run++;
            if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                tests_failed++;
                $display("FAIL random_model j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
        end
        hold = 1'b0; blank_mask = '0; dp_mask = '0;
    endtask

    task automatic test_midscan_reset();
        bit found = 1'b0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            tick();
            if (an === 4'b1101) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL midscan_wait: got no an=1101 within %0d cycles, want one", 2 * FRAME);
        end
        #2;
        Reset = 1'b0;
        #1;
        tests_run++;
        if ({an, dispcode, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL midscan_async: got an=%b seg=%b dp=%b ft=%b, want 1111 1111111 1 0", an, dispcode, dp, frame_tick);
        end
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        j = 0;
        m_snap = '0;
        for (int k = 0; k < FRAME + 4; k++) begin
            tick();
            tests_run++;
            if ({an, dispcode, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                tests_failed++;
                $display("FAIL after_reset j=%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b", j, an, dispcode, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_sel_switch();
        test_hold();
        test_masks();
        test_lzs();
        test_random();
        test_midscan_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
